fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller for the pipelined MIPS core. Owns the program counter, drives the instruction memory address, and registers the fetched word into the IF/ID stage register. Handles start/halt, ID-stage stalls, branch redirects with flush, and end-of-program detection. Sits between the instruction memory (combinational read) and the decode stage.

## Interface
- `RESET_PC`, 32'h0, PC loaded on reset and on restart.
- `MEM_BYTES`, 256, instruction memory size in bytes; valid fetch addresses are 0 .. MEM_BYTES-4.
- `PC_STEP`, 4, byte increment per sequential fetch.
- `clock`  in  1  single clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins fetching.
- `stall`  in  1  decode not ready; hold IF/ID and PC.
- `redirect`  in  1  taken branch/jump from EX; flush and reload PC.
- `redirect_pc`  in  32  byte target of the redirect.
- `imem_addr`  out  32  byte address to instruction memory; always equals PC.
- `imem_instruction`  in  32  word returned combinationally for `imem_addr`.
- `if_instruction`  out  32  registered fetched word.
- `if_pc`  out  32  address of `if_instruction`.
- `if_pc_plus4`  out  32  `if_pc + PC_STEP`.
- `if_valid`  out  1  IF/ID holds a real instruction.
- `halted`  out  1  high in HALT state.
- `fetch_count`  out  16  instructions captured since reset/restart; saturates at 16'hFFFF.

## Operation
- States: IDLE, RUN, HALT. Reset → IDLE.
- IDLE: PC held at RESET_PC, no capture. `start` → RUN.
- RUN, advance (no `stall`, no `redirect`): IF/ID ← {imem_instruction, PC, PC+PC_STEP}, `if_valid` ← 1, `fetch_count` += 1, PC ← PC+PC_STEP. If the captured PC = MEM_BYTES-4, go to HALT instead of running past the end; PC stays at MEM_BYTES-4.
- RUN, `stall` without `redirect`: PC, IF/ID, `if_valid`, and `fetch_count` hold.
- `redirect` (any state but IDLE) has priority over `stall`: `if_valid` ← 0, no capture, no count. PC ← {redirect_pc[31:2], 2'b00}. If the aligned target is ≥ MEM_BYTES, go to HALT with PC unchanged. Otherwise go to RUN, including from HALT.
- HALT: no capture. On the first cycle without `stall`, `if_valid` ← 0. `start` → RUN with PC ← RESET_PC, IF/ID cleared, `fetch_count` ← 0.
- `start` in RUN is ignored.
- Simultaneous `start` and `redirect` in HALT: `redirect` wins.
- `halted` = (state == HALT). `imem_addr` = PC, combinationally.
- Arithmetic is 32-bit modulo. Sequential overflow cannot occur because the HALT check precedes it.

## Timing
- Reset (asynchronous, immediate): PC = `imem_addr` = RESET_PC; `if_instruction` = 0, `if_pc` = 0, `if_pc_plus4` = 0; `if_valid` = 0; `halted` = 0; `fetch_count` = 0. Deassertion takes effect on the next edge. Reset mid-operation discards everything.
- `start` sampled at edge N → RUN after N. First capture at edge N+1. `if_valid` = 1 and `if_pc` = RESET_PC after N+1.
- Fetch latency: one edge from `imem_addr` to `if_instruction`. Throughput is one instruction per cycle when not stalled.
- Redirect sampled at edge N: `if_valid` = 0 after N. The target word is captured at N+1 (one bubble).
- The HALT transition occurs at the same edge that captures MEM_BYTES-4. `halted` is high the following cycle.

## Test plan
- Memory words 0x01098020 at 0, 0x014B8822 at 4, 0x02119020 at 8. Reset, pulse `start` → `if_pc` is 0, 4, 8 on three consecutive cycles with those words. `if_pc_plus4` is 4, 8, 12. `fetch_count` = 3.
- After `if_pc` = 4 is captured, hold `stall` 3 cycles → `if_instruction` = 0x014B8822, `imem_addr` = 8, and `fetch_count` are frozen. Release → `if_pc` = 8 the next cycle.
- `redirect` with `redirect_pc` = 0x0E while `stall` = 1 → `if_valid` = 0 the next cycle. `imem_addr` = 0x0C. `if_pc` = 0x0C the cycle after. Count does not increment for the bubble.
- MEM_BYTES = 16 → captures 0, 4, 8, 12, then `halted` = 1, `imem_addr` stays 12, `if_valid` drops once unstalled. `start` → fetch restarts at 0 with `fetch_count` = 0.
- `redirect_pc` = 0x40 with MEM_BYTES = 16 → HALT, `if_valid` = 0. Then `redirect_pc` = 4 in HALT → RUN, next `if_pc` = 4.
- Assert `reset_n` = 0 mid-RUN between edges → all outputs reach reset values immediately. After release, no fetch occurs until `start`.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, drives the instruction memory
// address and registers the fetched word into the IF/ID stage register.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 256,
    parameter logic [31:0] PC_STEP   = 32'd4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instruction,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        if_valid,
    output logic        halted,
    output logic [15:0] fetch_count
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);
    localparam logic [31:0] LAST_PC   = MEM_LIMIT - PC_STEP;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [31:0] pc_r;
    logic [31:0] if_instruction_r;
    logic [31:0] if_pc_r;
    logic [31:0] if_pc_plus4_r;
    logic        if_valid_r;
    logic        halted_r;
    logic [15:0] fetch_count_r;
    logic [31:0] target_s;
    logic        target_ok_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    // Word-aligned redirect target and whether it lies inside instruction memory.
    always_comb begin
        target_s    = redirect_pc & ~32'd3;
        target_ok_s = (target_s < MEM_LIMIT);
    end

    // Next-state decode; redirect outranks start and stall everywhere but IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) next_state_s = ST_RUN;
                else       next_state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (redirect)                   next_state_s = target_ok_s ? ST_RUN : ST_HALT;
                else if (!stall && pc_r == LAST_PC) next_state_s = ST_HALT;
                else                            next_state_s = ST_RUN;
            end
            ST_HALT: begin
                if (redirect)   next_state_s = target_ok_s ? ST_RUN : ST_HALT;
                else if (start) next_state_s = ST_RUN;
                else            next_state_s = ST_HALT;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Sequencer state, PC and IF/ID stage register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r          <= ST_IDLE;
            halted_r         <= 1'b0;
            pc_r             <= RESET_PC;
            if_instruction_r <= 32'h0000_0000;
            if_pc_r          <= 32'h0000_0000;
            if_pc_plus4_r    <= 32'h0000_0000;
            if_valid_r       <= 1'b0;
            fetch_count_r    <= 16'h0000;
        end else begin
            state_r  <= next_state_s;
            halted_r <= (next_state_s == ST_HALT);
            case (state_r)
                ST_IDLE: begin
                    pc_r <= RESET_PC;
                end
                ST_RUN: begin
                    if (redirect) begin
                        if_valid_r <= 1'b0;
                        if (target_ok_s) pc_r <= target_s;
                    end else if (!stall) begin
                        if_instruction_r <= imem_instruction;
                        if_pc_r          <= pc_r;
                        if_pc_plus4_r    <= pc_r + PC_STEP;
                        if_valid_r       <= 1'b1;
                        fetch_count_r    <= sat_inc(fetch_count_r);
                        // The last word leaves PC parked on it rather than stepping past memory.
                        if (pc_r != LAST_PC) pc_r <= pc_r + PC_STEP;
                    end
                end
                ST_HALT: begin
                    if (redirect) begin
                        if_valid_r <= 1'b0;
                        if (target_ok_s) pc_r <= target_s;
                    end else if (start) begin
                        pc_r             <= RESET_PC;
                        if_instruction_r <= 32'h0000_0000;
                        if_pc_r          <= 32'h0000_0000;
                        if_pc_plus4_r    <= 32'h0000_0000;
                        if_valid_r       <= 1'b0;
                        fetch_count_r    <= 16'h0000;
                    end else if (!stall) begin
                        if_valid_r <= 1'b0;
                    end
                end
                default: begin
                    pc_r <= RESET_PC;
                end
            endcase
        end
    end

    assign imem_addr      = pc_r;
    assign if_instruction = if_instruction_r;
    assign if_pc          = if_pc_r;
    assign if_pc_plus4    = if_pc_plus4_r;
    assign if_valid       = if_valid_r;
    assign halted         = halted_r;
    assign fetch_count    = fetch_count_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus randomized traffic against
// a behavioural model, on a 256-byte and a 16-byte memory instance.
module tb_fetch_sequencer;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic [31:0] mem [0:63];

    logic [31:0] addr_w [2];
    logic [31:0] imem_w [2];
    logic [31:0] ins_w  [2];
    logic [31:0] ipc_w  [2];
    logic [31:0] ip4_w  [2];
    logic        valid_w[2];
    logic        halt_w [2];
    logic [15:0] cnt_w  [2];

    // Behavioural model: one entry per instance.
    int          limit [2];
    bit          m_run [2];
    bit          m_halt[2];
    logic [31:0] m_pc  [2];
    logic [31:0] m_ins [2];
    logic [31:0] m_ipc [2];
    logic [31:0] m_ip4 [2];
    bit          m_valid[2];
    int          m_cnt [2];

    int checks;
    int fails;

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & 32'd63);
    endfunction

    assign imem_w[0] = mem[widx(addr_w[0])];
    assign imem_w[1] = mem[widx(addr_w[1])];

    fetch_sequencer #(.MEM_BYTES(256)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_addr(addr_w[0]), .imem_instruction(imem_w[0]),
        .if_instruction(ins_w[0]), .if_pc(ipc_w[0]), .if_pc_plus4(ip4_w[0]),
        .if_valid(valid_w[0]), .halted(halt_w[0]), .fetch_count(cnt_w[0])
    );

    fetch_sequencer #(.MEM_BYTES(16)) dut16 (
        .clock(clock), .reset_n(reset_n), .start(start), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_addr(addr_w[1]), .imem_instruction(imem_w[1]),
        .if_instruction(ins_w[1]), .if_pc(ipc_w[1]), .if_pc_plus4(ip4_w[1]),
        .if_valid(valid_w[1]), .halted(halt_w[1]), .fetch_count(cnt_w[1])
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0; m_halt[k] = 0; m_pc[k] = 32'd0; m_ins[k] = 32'd0;
            m_ipc[k] = 32'd0; m_ip4[k] = 32'd0; m_valid[k] = 0; m_cnt[k] = 0;
        end
    endtask

    // One clock of the fetch rules, applied to the inputs seen at the edge.
    task automatic model_step();
        logic [31:0] tgt;
        tgt = {redirect_pc[31:2], 2'b00};
        for (int k = 0; k < 2; k++) begin
            if (!m_run[k] && !m_halt[k]) begin
                if (start) m_run[k] = 1;
            end else if (redirect) begin
                m_valid[k] = 0;
                if (tgt >= 32'(limit[k])) begin
                    m_run[k] = 0; m_halt[k] = 1;
                end else begin
                    m_pc[k] = tgt; m_run[k] = 1; m_halt[k] = 0;
                end
            end else if (m_run[k]) begin
                if (!stall) begin
                    m_ins[k] = mem[widx(m_pc[k])];
                    m_ipc[k] = m_pc[k];
                    m_ip4[k] = m_pc[k] + 32'd4;
                    m_valid[k] = 1;
                    if (m_cnt[k] < 65535) m_cnt[k] = m_cnt[k] + 1;
                    if (m_pc[k] == 32'(limit[k] - 4)) begin
                        m_run[k] = 0; m_halt[k] = 1;
                    end else begin
                        m_pc[k] = m_pc[k] + 32'd4;
                    end
                end
            end else begin
                if (start) begin
                    m_run[k] = 1; m_halt[k] = 0; m_pc[k] = 32'd0; m_ins[k] = 32'd0;
                    m_ipc[k] = 32'd0; m_ip4[k] = 32'd0; m_valid[k] = 0; m_cnt[k] = 0;
                end else if (!stall) begin
                    m_valid[k] = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b0; start = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (addr_w[0] !== 32'd0) begin fails++; $display("FAIL reset_addr: got %h want 0", addr_w[0]); end
        checks++; if (ins_w[0] !== 32'd0) begin fails++; $display("FAIL reset_ins: got %h want 0", ins_w[0]); end
        checks++; if (ip4_w[0] !== 32'd0) begin fails++; $display("FAIL reset_pc4: got %h want 0", ip4_w[0]); end
        checks++; if (valid_w[0] !== 1'b0 || halt_w[0] !== 1'b0) begin fails++; $display("FAIL reset_flags: got valid=%b halted=%b want 0 0", valid_w[0], halt_w[0]); end
        checks++; if (cnt_w[0] !== 16'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", cnt_w[0]); end
        tick(); tick();
        checks++; if (valid_w[0] !== 1'b0 || addr_w[0] !== 32'd0) begin fails++; $display("FAIL idle_hold: got valid=%b addr=%h want 0 0", valid_w[0], addr_w[0]); end
    endtask

    task automatic test_sequential();
        logic [31:0] words [3];
        words[0] = 32'h0109_8020; words[1] = 32'h014B_8822; words[2] = 32'h0211_9020;
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (ipc_w[0] !== 32'(4 * i) || ins_w[0] !== words[i] || ip4_w[0] !== 32'(4 * i + 4) || valid_w[0] !== 1'b1)
                begin fails++; $display("FAIL seq_capture%0d: got pc=%h ins=%h pc4=%h v=%b want pc=%h ins=%h pc4=%h v=1", i, ipc_w[0], ins_w[0], ip4_w[0], valid_w[0], 32'(4 * i), words[i], 32'(4 * i + 4)); end
        end
        checks++; if (cnt_w[0] !== 16'd3) begin fails++; $display("FAIL seq_count: got %0d want 3", cnt_w[0]); end
    endtask

    task automatic test_stall_redirect();
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (ins_w[0] !== 32'h014B_8822 || addr_w[0] !== 32'd8 || cnt_w[0] !== 16'd2 || ipc_w[0] !== 32'd4)
                begin fails++; $display("FAIL stall_hold%0d: got ins=%h addr=%h cnt=%0d pc=%h want 014b8822 8 2 4", i, ins_w[0], addr_w[0], cnt_w[0], ipc_w[0]); end
        end
        stall = 1'b0; tick();
        checks++; if (ipc_w[0] !== 32'd8 || cnt_w[0] !== 16'd3) begin fails++; $display("FAIL stall_release: got pc=%h cnt=%0d want 8 3", ipc_w[0], cnt_w[0]); end
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_000E; tick();
        checks++; if (valid_w[0] !== 1'b0 || addr_w[0] !== 32'h0C || cnt_w[0] !== 16'd3)
            begin fails++; $display("FAIL redirect_bubble: got v=%b addr=%h cnt=%0d want 0 c 3", valid_w[0], addr_w[0], cnt_w[0]); end
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; tick();
        checks++; if (ipc_w[0] !== 32'h0C || ins_w[0] !== mem[3] || valid_w[0] !== 1'b1 || cnt_w[0] !== 16'd4)
            begin fails++; $display("FAIL redirect_target: got pc=%h ins=%h v=%b cnt=%0d want c %h 1 4", ipc_w[0], ins_w[0], valid_w[0], cnt_w[0], mem[3]); end
    endtask

    task automatic test_end_of_memory();
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (ipc_w[1] !== 32'(4 * i) || ins_w[1] !== mem[i]) begin fails++; $display("FAIL end_capture%0d: got pc=%h ins=%h want %h %h", i, ipc_w[1], ins_w[1], 32'(4 * i), mem[i]); end
        end
        checks++; if (halt_w[1] !== 1'b1 || addr_w[1] !== 32'd12 || valid_w[1] !== 1'b1)
            begin fails++; $display("FAIL end_halt: got halted=%b addr=%h v=%b want 1 c 1", halt_w[1], addr_w[1], valid_w[1]); end
        stall = 1'b1; tick();
        checks++; if (halt_w[1] !== 1'b1 || addr_w[1] !== 32'd12 || valid_w[1] !== 1'b1)
            begin fails++; $display("FAIL end_stalled: got halted=%b addr=%h v=%b want 1 c 1", halt_w[1], addr_w[1], valid_w[1]); end
        stall = 1'b0; tick();
        checks++; if (valid_w[1] !== 1'b0 || cnt_w[1] !== 16'd4) begin fails++; $display("FAIL end_drop: got v=%b cnt=%0d want 0 4", valid_w[1], cnt_w[1]); end
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (halt_w[1] !== 1'b0 || cnt_w[1] !== 16'd0 || addr_w[1] !== 32'd0 || ipc_w[1] !== 32'd0)
            begin fails++; $display("FAIL end_restart: got halted=%b cnt=%0d addr=%h pc=%h want 0 0 0 0", halt_w[1], cnt_w[1], addr_w[1], ipc_w[1]); end
        tick();
        checks++; if (ipc_w[1] !== 32'd0 || valid_w[1] !== 1'b1 || cnt_w[1] !== 16'd1)
            begin fails++; $display("FAIL end_refetch: got pc=%h v=%b cnt=%0d want 0 1 1", ipc_w[1], valid_w[1], cnt_w[1]); end
    endtask

    task automatic test_redirect_out_of_range();
        redirect = 1'b1; redirect_pc = 32'h0000_0040; tick();
        checks++; if (halt_w[1] !== 1'b1 || valid_w[1] !== 1'b0 || addr_w[1] !== 32'd4 || cnt_w[1] !== 16'd1)
            begin fails++; $display("FAIL oob_halt: got halted=%b v=%b addr=%h cnt=%0d want 1 0 4 1", halt_w[1], valid_w[1], addr_w[1], cnt_w[1]); end
        start = 1'b1; redirect_pc = 32'd4; tick(); start = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        checks++; if (halt_w[1] !== 1'b0 || addr_w[1] !== 32'd4 || valid_w[1] !== 1'b0 || cnt_w[1] !== 16'd1)
            begin fails++; $display("FAIL oob_recover: got halted=%b addr=%h v=%b cnt=%0d want 0 4 0 1", halt_w[1], addr_w[1], valid_w[1], cnt_w[1]); end
        tick();
        checks++; if (ipc_w[1] !== 32'd4 || ins_w[1] !== mem[1] || valid_w[1] !== 1'b1 || cnt_w[1] !== 16'd2)
            begin fails++; $display("FAIL oob_refetch: got pc=%h ins=%h v=%b cnt=%0d want 4 %h 1 2", ipc_w[1], ins_w[1], valid_w[1], cnt_w[1], mem[1]); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            start       = ($urandom_range(0, 99) < 6);
            stall       = ($urandom_range(0, 99) < 25);
            redirect    = ($urandom_range(0, 99) < 8);
            redirect_pc = 32'($urandom_range(0, 300));
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (addr_w[k] !== m_pc[k] || ins_w[k] !== m_ins[k] || ipc_w[k] !== m_ipc[k] || ip4_w[k] !== m_ip4[k] ||
                    valid_w[k] !== m_valid[k] || halt_w[k] !== m_halt[k] || cnt_w[k] !== 16'(m_cnt[k])) begin
                    fails++;
                    $display("FAIL random%0d_dut%0d: got addr=%h ins=%h pc=%h pc4=%h v=%b h=%b cnt=%0d want %h %h %h %h %b %b %0d",
                             n, k, addr_w[k], ins_w[k], ipc_w[k], ip4_w[k], valid_w[k], halt_w[k], cnt_w[k],
                             m_pc[k], m_ins[k], m_ipc[k], m_ip4[k], m_valid[k], m_halt[k], m_cnt[k]);
                end
            end
        end
        start = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    endtask

    task automatic test_async_reset();
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (addr_w[k] !== 32'd0 || ins_w[k] !== 32'd0 || ipc_w[k] !== 32'd0 || ip4_w[k] !== 32'd0 ||
                valid_w[k] !== 1'b0 || halt_w[k] !== 1'b0 || cnt_w[k] !== 16'd0)
                begin fails++; $display("FAIL async_reset_dut%0d: got addr=%h ins=%h pc=%h pc4=%h v=%b h=%b cnt=%0d want all 0", k, addr_w[k], ins_w[k], ipc_w[k], ip4_w[k], valid_w[k], halt_w[k], cnt_w[k]); end
        end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (3) tick();
        checks++; if (valid_w[0] !== 1'b0 || addr_w[0] !== 32'd0 || cnt_w[0] !== 16'd0)
            begin fails++; $display("FAIL post_reset_idle: got v=%b addr=%h cnt=%0d want 0 0 0", valid_w[0], addr_w[0], cnt_w[0]); end
    endtask

    initial begin
        clock = 1'b0; reset_n = 1'b0; start = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        checks = 0; fails = 0;
        limit[0] = 256; limit[1] = 16;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h0109_8020; mem[1] = 32'h014B_8822; mem[2] = 32'h0211_9020;
        model_reset();
        test_reset();
        test_sequential();
        test_stall_redirect();
        test_end_of_memory();
        test_redirect_out_of_range();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
